// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcodes and FSM state encodings for the sequential ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MOVA   = 3'd0;
    localparam logic [OP_W-1:0] OP_MOVB   = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD    = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB    = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd5;
    localparam logic [OP_W-1:0] OP_SHIFTR = 3'd6;
    localparam logic [OP_W-1:0] OP_SHIFTL = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t MUL_RUN = 2'd1;
    localparam state_t DIV_RUN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seq_alu_iter_muldiv.sv
// ============================================================================
// Module : iter_muldiv
// Brief  : Shared shift-add multiplier / restoring divider, one bit per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] sreg_s;
    logic [WIDTH:0]   trial;
    logic             ge;

    // The load cycle already performs the first iteration, so the final
    // iteration is presented combinationally on result while last is high.
    always_comb begin
        acc_s  = load ? '0 : acc_q;
        sreg_s = load ? (is_div ? a : b) : sreg_q;
        opnd_d = load ? (is_div ? b : a) : opnd_q;
        div_d  = load ? is_div : div_q;

        trial = {acc_s, sreg_s[WIDTH-1]};
        ge    = trial[WIDTH] || (trial[WIDTH-1:0] >= opnd_d);

        if (div_d) begin
            acc_d  = ge ? (trial[WIDTH-1:0] - opnd_d) : trial[WIDTH-1:0];
            sreg_d = {sreg_s[WIDTH-2:0], ge};
        end else begin
            acc_d  = {acc_s[WIDTH-2:0], 1'b0} + (sreg_s[WIDTH-1] ? opnd_d : '0);
            sreg_d = {sreg_s[WIDTH-2:0], 1'b0};
        end

        last = (cnt_q == CW'(WIDTH - 1));

        if (load) begin
            cnt_d = CW'(1);
        end else if (cnt_q != '0) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        result = div_d ? sreg_d : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sreg_q <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load || (cnt_q != '0)) begin
                acc_q  <= acc_d;
                sreg_q <= sreg_d;
                opnd_q <= opnd_d;
                div_q  <= div_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module : seq_alu
// Brief  : Registered ALU with start/done handshake and iterative MUL/DIV.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHIFT_VAR = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] abus_out,
    input  logic [WIDTH-1:0] bbus_out,
    output logic [WIDTH-1:0] cbus_in,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cbus_q, cbus_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic             md_load;
    logic             md_is_div;
    logic [WIDTH-1:0] md_result;
    logic             md_last;

    logic [WIDTH:0]   sum;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             dz_new;
    logic             upd;

    assign md_is_div = (alu_op == OP_DIV);

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter_muldiv (
        .clk    (clock),
        .rst_n  (reset_n),
        .load   (md_load),
        .is_div (md_is_div),
        .a      (abus_out),
        .b      (bbus_out),
        .result (md_result),
        .last   (md_last)
    );

    always_comb begin
        state_d = state_q;
        cbus_d  = cbus_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        md_load = 1'b0;
        res     = '0;
        c_new   = 1'b0;
        dz_new  = 1'b0;
        upd     = 1'b0;

        sum   = {1'b0, abus_out} + {1'b0, bbus_out};
        shamt = (SHIFT_VAR != 0) ? bbus_out[SW-1:0] : SW'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    upd = 1'b1;
                    case (alu_op)
                        OP_MOVA:   res = abus_out;
                        OP_MOVB:   res = bbus_out;
                        OP_ADD: begin
                            res   = sum[WIDTH-1:0];
                            c_new = sum[WIDTH];
                        end
                        OP_SUB: begin
                            res   = abus_out - bbus_out;
                            c_new = (abus_out < bbus_out);
                        end
                        OP_MUL: begin
                            upd     = 1'b0;
                            md_load = 1'b1;
                            state_d = MUL_RUN;
                        end
                        OP_DIV: begin
                            // Divide-by-zero completes at once with a saturated quotient.
                            if (bbus_out == '0) begin
                                res    = '1;
                                dz_new = 1'b1;
                            end else begin
                                upd     = 1'b0;
                                md_load = 1'b1;
                                state_d = DIV_RUN;
                            end
                        end
                        OP_SHIFTR: res = abus_out >> shamt;
                        default:   res = abus_out << shamt;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (md_last) begin
                    res     = md_result;
                    upd     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (upd) begin
            cbus_d = res;
            n_d    = res[WIDTH-1];
            z_d    = (res == '0);
            c_d    = c_new;
            dz_d   = dz_new;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cbus_q  <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cbus_q  <= cbus_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign cbus_in = cbus_q;
    assign n       = n_q;
    assign z       = z_q;
    assign c       = c_q;
    assign dz      = dz_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire
